// File: rtl/demux_pkg.sv
// Shared constants, state encoding and helpers for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t PKT  = 1'b1;

    function automatic logic [NUM_OUT-1:0] onehot4(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] v;
        v = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    // m_valid is one-hot (or zero), so an OR-encoder is sufficient.
    function automatic logic [SEL_W-1:0] enc4(input logic [NUM_OUT-1:0] v);
        return {v[3] | v[2], v[3] | v[1]};
    endfunction

endpackage

// File: rtl/demux_out_reg.sv
// Single output slot: one-hot valid, shared data and last, loaded on input accept, cleared on pop.
module demux_out_reg
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               pop,
    input  logic [NUM_OUT-1:0] load_vec,
    input  logic [DATA_W-1:0]  load_data,
    input  logic               load_last,
    output logic [NUM_OUT-1:0] valid,
    output logic [DATA_W-1:0]  data,
    output logic               last
);

    // A load in the same cycle as a pop reloads the slot, so no bubble appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= load_vec;
            data  <= load_data;
            last  <= load_last;
        end else if (pop) begin
            valid <= '0;
        end
    end

endmodule

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demux with packet lock on sel.
// Optional per-output completed-packet counters when DEMUX_PKT_CNT_EN is defined.
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_last,
    input  logic [SEL_W-1:0]     sel,
    output logic [NUM_OUT-1:0]   m_valid,
    input  logic [NUM_OUT-1:0]   m_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_last,
    output logic                 busy
`ifdef DEMUX_PKT_CNT_EN
    ,
    output logic [NUM_OUT*CNT_W-1:0] pkt_cnt
`endif
);

    state_t           state;
    logic [SEL_W-1:0] dest_q;
    logic [SEL_W-1:0] dest;
    logic [SEL_W-1:0] route;
    logic             out_v;
    logic             pop;
    logic             accept;

    assign out_v   = |m_valid;
    assign dest    = enc4(m_valid);
    assign pop     = out_v & m_ready[dest];
    assign s_ready = !out_v | m_ready[dest];
    assign accept  = s_valid & s_ready;
    assign route   = (state == IDLE) ? sel : dest_q;
    assign busy    = (state == PKT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            dest_q <= '0;
        end else if (accept) begin
            case (state)
                IDLE: if (!s_last) begin
                    state  <= PKT;
                    dest_q <= sel;
                end
                default: if (s_last) state <= IDLE;
            endcase
        end
    end

    demux_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .pop       (pop),
        .load_vec  (onehot4(route)),
        .load_data (s_data),
        .load_last (s_last),
        .valid     (m_valid),
        .data      (m_data),
        .last      (m_last)
    );

`ifdef DEMUX_PKT_CNT_EN
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                pkt_cnt[i*CNT_W +: CNT_W] <= '0;
            else if (pop && m_last && dest == SEL_W'(i))
                pkt_cnt[i*CNT_W +: CNT_W] <= pkt_cnt[i*CNT_W +: CNT_W] + 1'b1;
        end
    end
`endif

endmodule
